// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline control path
// (sequencing controller and hazard unit).
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        REDIR = 2'd1,
        DWAIT = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic pc_we;
        logic if_de_we;
        logic if_de_flush;
        logic de_ex_we;
        logic de_ex_flush;
        logic ex_mem_we;
        logic mem_wb_we;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_FLOW = '{
        pc_we: 1'b1, if_de_we: 1'b1, if_de_flush: 1'b0,
        de_ex_we: 1'b1, de_ex_flush: 1'b0, ex_mem_we: 1'b1, mem_wb_we: 1'b1
    };

    localparam stage_ctrl_t CTRL_FROZEN = '0;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    function automatic logic opc_writes_rd(input logic [6:0] opc);
        return !(opc == OPC_STORE || opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/pipe_seq_ctrl_perf_counters.sv
// Stall and redirect performance counters with synchronous active-low clear.
module perf_counters
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_inc_i,
    input  logic             flush_inc_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_inc_i ? stall_q + 1'b1 : stall_q;
        flush_d = flush_inc_i ? flush_q + 1'b1 : flush_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: turns load-use, redirect and data-memory
// wait events into per-stage write-enable and flush controls.
module pipe_seq_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REDIRECT_EXTRA = 1,
    parameter int unsigned DWAIT_TIMEOUT  = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load_use_haz,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             if_de_we,
    output logic             if_de_flush,
    output logic             de_ex_we,
    output logic             de_ex_flush,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             dmem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = (DWAIT_TIMEOUT > 1) ? $clog2(DWAIT_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX    = WAIT_W'(DWAIT_TIMEOUT);
    localparam logic [1:0]        REDIR_RLOAD = 2'(REDIRECT_EXTRA);

    seq_state_t        state_q, state_d;
    seq_state_t        saved_q, saved_d;
    seq_state_t        eff_state;
    logic [1:0]        redir_cnt_q, redir_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic              freeze;
    logic              stall_inc, flush_inc;
    stage_ctrl_t       ctrl;

    assign freeze = dmem_req & ~dmem_ready;

    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        redir_cnt_d = redir_cnt_q;
        wait_cnt_d  = '0;
        err_d       = err_q;
        ctrl        = CTRL_FLOW;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        // DWAIT resumes whatever state it interrupted; REDIR counter is simply held
        eff_state   = (state_q == DWAIT) ? saved_q : state_q;

        if (!RST_N) begin
            ctrl = CTRL_FLOW;
        end else if (freeze) begin
            ctrl       = CTRL_FROZEN;
            state_d    = DWAIT;
            saved_d    = eff_state;
            stall_inc  = 1'b1;
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if (wait_cnt_d == WAIT_MAX) begin
                err_d = 1'b1;
            end
        end else if (ex_redirect) begin
            ctrl.if_de_flush = 1'b1;
            ctrl.de_ex_flush = 1'b1;
            flush_inc        = 1'b1;
            redir_cnt_d      = REDIR_RLOAD;
            state_d          = (REDIRECT_EXTRA > 0) ? REDIR : RUN;
        end else if (eff_state == REDIR) begin
            ctrl.if_de_flush = 1'b1;
            redir_cnt_d      = redir_cnt_q - 1'b1;
            state_d          = (redir_cnt_d == 2'd0) ? RUN : REDIR;
        end else begin
            state_d = RUN;
            if (load_use_haz) begin
                ctrl.pc_we       = 1'b0;
                ctrl.if_de_we    = 1'b0;
                ctrl.de_ex_flush = 1'b1;
                stall_inc        = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= RUN;
            saved_q     <= RUN;
            redir_cnt_q <= '0;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            redir_cnt_q <= redir_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
        end
    end

    perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk_i      (CLK),
        .rst_ni     (RST_N),
        .stall_inc_i(stall_inc),
        .flush_inc_i(flush_inc),
        .stall_cnt_o(stall_cnt),
        .flush_cnt_o(flush_cnt)
    );

    assign pc_we       = ctrl.pc_we;
    assign if_de_we    = ctrl.if_de_we;
    assign if_de_flush = ctrl.if_de_flush;
    assign de_ex_we    = ctrl.de_ex_we;
    assign de_ex_flush = ctrl.de_ex_flush;
    assign ex_mem_we   = ctrl.ex_mem_we;
    assign mem_wb_we   = ctrl.mem_wb_we;
    assign dmem_err    = err_q;

endmodule
